// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI flash read arbiter.
//   ADDR_W     : flash byte address width
//   OP_RD      : READ opcode (0x03)
//   OP_FAST_RD : FAST_READ opcode (0x0B), used when SPI_FLASH_ARB_FAST_READ_EN is defined
//   state_t    : transaction sequencer states
package spi_flash_pkg;
    localparam int ADDR_W = 24;
    localparam logic [7:0] OP_RD      = 8'h03;
    localparam logic [7:0] OP_FAST_RD = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;
endpackage

// File: rtl/spi_shift_byte.sv
// One-byte SPI mode-0 shifter with built-in SCK divider.
//   clk, rst   : system clock, synchronous active-high reset
//   start      : load tx_byte and begin a byte (SCK restarts low); may coincide with byte_last
//   tx_byte    : byte to transmit, MSB first
//   miso       : serial input, sampled on SCK rising
//   sck, mosi  : serial clock (idle low) and data out (changes on SCK falling)
//   byte_last  : high in the cycle whose clock edge produces the 8th SCK falling edge
//   rx_byte    : received byte, complete while byte_last is high
module spi_shift_byte
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       byte_last,
    output logic [7:0] rx_byte
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic             active_q, active_d;
    logic             sck_q, sck_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic             tick;

    // tick marks the cycle whose edge toggles SCK
    assign tick      = active_q && (div_q == DIV_MAX);
    assign byte_last = tick && sck_q && (bit_q == 3'd7);
    assign sck       = sck_q;
    assign mosi      = tx_q[7];
    assign rx_byte   = rx_q;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (start) begin
            // Start wins over the falling edge of the previous byte so bytes run gap-free
            active_d = 1'b1;
            sck_d    = 1'b0;
            div_d    = '0;
            bit_d    = '0;
            tx_d     = tx_byte;
        end else if (active_q) begin
            if (tick) begin
                div_d = '0;
                sck_d = ~sck_q;
                if (!sck_q) begin
                    rx_d = {rx_q[6:0], miso};
                end else begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) active_d = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end
endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-requester round-robin read controller for an M25-series SPI flash (mode 0).
// Sequence per request: opcode, 24-bit address, [dummy byte], len data bytes, CS-high gap.
// Define SPI_FLASH_ARB_FAST_READ_EN to use FAST_READ (0x0B) with one dummy byte.
//   clk, rst          : system clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake; ready is one-hot and only in IDLE
//   req_addr, req_len : {req1, req0} start address and byte count (0 = null request)
//   rd_data/valid     : returned byte with one-cycle strobe, rd_owner = requester
//   done              : one-cycle completion pulse per requester
//   busy              : high from the cycle after accept until back in IDLE
//   M25_CLK/NCS/DO/DI : flash pins
module spi_flash_arbiter
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int CS_HIGH_MIN = 4,
    parameter int LEN_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [47:0]        req_addr,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               rd_owner,
    output logic [1:0]         done,
    output logic               busy,
    output logic               M25_CLK,
    output logic               M25_NCS,
    output logic               M25_DO,
    input  logic               M25_DI
);
`ifdef SPI_FLASH_ARB_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif
    localparam logic [7:0] OPCODE = FAST_EN ? OP_FAST_RD : OP_RD;
    localparam int GAP_W = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_HIGH_MIN - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;      // requester granted most recently
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          idx_q, idx_d;        // address byte in flight
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                ncs_q, ncs_d;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [1:0]          done_q, done_d;

    logic [1:0]          grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                sh_start, byte_last;
    logic [7:0]          sh_tx, rx_byte;

    spi_shift_byte #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .start     (sh_start),
        .tx_byte   (sh_tx),
        .miso      (M25_DI),
        .sck       (M25_CLK),
        .mosi      (M25_DO),
        .byte_last (byte_last),
        .rx_byte   (rx_byte)
    );

    // Round robin: on contention grant the requester not served last
    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE && !rst) begin
            if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
            else                    grant = req_valid;
        end
    end

    assign sel_addr  = grant[1] ? req_addr[47:24] : req_addr[23:0];
    assign sel_len   = grant[1] ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
    assign req_ready = grant;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_owner  = owner_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign M25_NCS   = ncs_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        ncs_d      = ncs_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 2'b00;
        sh_start   = 1'b0;
        sh_tx      = 8'h00;
        case (state_q)
            ST_IDLE: if (grant != 2'b00) begin
                owner_d = grant[1];
                last_d  = grant[1];
                addr_d  = sel_addr;
                len_d   = sel_len;
                if (sel_len == '0) begin
                    // Null request: one busy cycle carrying done, flash untouched
                    state_d = ST_GAP;
                    gap_d   = GAP_MAX;
                    done_d  = grant;
                end else begin
                    state_d  = ST_CMD;
                    ncs_d    = 1'b0;
                    sh_start = 1'b1;
                    sh_tx    = OPCODE;
                end
            end
            ST_CMD: if (byte_last) begin
                state_d  = ST_ADDR;
                idx_d    = 2'd0;
                sh_start = 1'b1;
                sh_tx    = addr_q[23:16];
            end
            ST_ADDR: if (byte_last) begin
                sh_start = 1'b1;
                if (idx_q == 2'd2) begin
`ifdef SPI_FLASH_ARB_FAST_READ_EN
                    state_d = ST_DUMMY;
`else
                    state_d = ST_DATA;
`endif
                end else begin
                    idx_d = idx_q + 2'd1;
                    sh_tx = (idx_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
                end
            end
`ifdef SPI_FLASH_ARB_FAST_READ_EN
            ST_DUMMY: if (byte_last) begin
                state_d  = ST_DATA;
                sh_start = 1'b1;
            end
`endif
            ST_DATA: if (byte_last) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rx_byte;
                len_d      = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    // Last byte: SCK falls (shifter idles), CS rises, done in the same cycle
                    state_d = ST_GAP;
                    ncs_d   = 1'b1;
                    gap_d   = '0;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                end else begin
                    sh_start = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_MAX) state_d = ST_IDLE;
                else                  gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            ncs_q      <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            ncs_q      <= ncs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter: flash pin model, cycle-level
// transaction-timing model, and directed tests with literal expectations.
module tb_spi_flash_arbiter;
    localparam int CLK_DIV     = 2;
    localparam int CS_HIGH_MIN = 4;
    localparam int LEN_W       = 16;
    localparam int BYTE_CYC    = 16 * CLK_DIV;
`ifdef SPI_FLASH_ARB_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic               clk, rst;
    logic [1:0]         req_valid, req_ready;
    logic [47:0]        req_addr;
    logic [2*LEN_W-1:0] req_len;
    logic [7:0]         rd_data;
    logic               rd_valid, rd_owner, busy;
    logic [1:0]         done;
    logic               M25_CLK, M25_NCS, M25_DO, M25_DI;

    spi_flash_arbiter #(.CLK_DIV(CLK_DIV), .CS_HIGH_MIN(CS_HIGH_MIN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_owner(rd_owner), .done(done), .busy(busy), .M25_CLK(M25_CLK),
        .M25_NCS(M25_NCS), .M25_DO(M25_DO), .M25_DI(M25_DI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Flash contents: byte at address a
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return (a[0] ? 8'h5A : 8'hA5) ^ {1'b0, a[7:1]};
    endfunction

    // ---------------- flash pin model ----------------
    int          fl_cnt = 0;
    logic [31:0] fl_sh  = '0;
    logic [23:0] fl_addr = '0;
    logic [7:0]  fl_byte;
    int          fl_k, fl_b;
    logic [7:0]  do_log[$];
    int          sck_rises = 0;

    always @(negedge M25_NCS) fl_cnt = 0;
    always @(posedge M25_CLK) begin
        sck_rises++;
        if (!M25_NCS) begin
            fl_sh = {fl_sh[30:0], M25_DO};
            fl_cnt++;
            if (fl_cnt % 8 == 0) do_log.push_back(fl_sh[7:0]);
            if (fl_cnt == 32) fl_addr = fl_sh[23:0];
        end
    end
    always @(negedge M25_CLK) begin
        if (!M25_NCS && fl_cnt >= 8*HDR) begin
            fl_k    = (fl_cnt - 8*HDR) / 8;
            fl_b    = 7 - (fl_cnt - 8*HDR) % 8;
            fl_byte = mem_byte(fl_addr + 24'(fl_k));
            M25_DI  = fl_byte[fl_b];
        end
    end

    // ---------------- event logs ----------------
    logic [8:0] rv_log[$];
    logic [1:0] done_log[$];
    int         ncs_lens[$], gap_lens[$], acc_log[$];
    int         lo_cnt = 0, hi_cnt = 0;
    bit         had_low = 0;

    always @(negedge clk) begin
        if (rd_valid) rv_log.push_back({rd_owner, rd_data});
        if (done != 2'b00) done_log.push_back(done);
        if (!rst && (req_valid & req_ready) != 2'b00) acc_log.push_back(req_ready[1] ? 1 : 0);
        if (M25_NCS === 1'b0) begin
            lo_cnt++;
            if (hi_cnt > 0 && had_low) gap_lens.push_back(hi_cnt);
            hi_cnt = 0; had_low = 1;
        end else begin
            hi_cnt++;
            if (lo_cnt > 0) ncs_lens.push_back(lo_cnt);
            lo_cnt = 0;
        end
    end

    task automatic clear_logs();
        rv_log.delete(); done_log.delete(); ncs_lens.delete(); gap_lens.delete();
        acc_log.delete(); do_log.delete(); sck_rises = 0; had_low = 0; lo_cnt = 0; hi_cnt = 0;
    endtask

    // ---------------- transaction timing model ----------------
    // e counts cycles since accept (1 = first busy cycle). CS low for e in 1..total,
    // byte b completes at e = BYTE_CYC*(b+1)+1, gap follows for CS_HIGH_MIN cycles.
    bit          chk_en = 0;
    bit          m_active = 0;
    logic        m_last = 1'b1, m_owner = 1'b0;
    logic [23:0] m_addr = '0;
    int          m_len = 0, m_e = 0, m_end = 0, m_total = 0;

    always @(negedge clk) begin : cmp
        logic [1:0]  x_ready, x_done;
        logic        x_low, x_sck, x_do, x_rv;
        logic [31:0] hdr;
        int          p, q, k;
        if (chk_en) begin
            x_ready = 2'b00;
            if (!m_active && !rst)
                x_ready = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
            x_low = m_active && m_len != 0 && m_e <= m_total;
            p     = m_e - 1;
            hdr   = {OPC, m_addr};
            x_sck = x_low && ((p % (2*CLK_DIV)) >= CLK_DIV);
            x_do  = 1'b0;
            if (x_low && (p / (2*CLK_DIV)) < 32) x_do = hdr[31 - p / (2*CLK_DIV)];
            x_done = 2'b00;
            if (m_active && ((m_len == 0 && m_e == 1) || (m_len != 0 && m_e == m_total + 1)))
                x_done = m_owner ? 2'b10 : 2'b01;
            x_rv = 1'b0;
            k    = 0;
            if (m_active && m_len != 0 && m_e > 1 && (p % BYTE_CYC) == 0) begin
                q    = p / BYTE_CYC;
                k    = q - HDR - 1;
                x_rv = (k >= 0 && k < m_len);
            end
            chk("req_ready", req_ready, x_ready);
            chk("busy", busy, m_active);
            chk("ncs", M25_NCS, !x_low);
            chk("sck", M25_CLK, x_sck);
            chk("mosi", M25_DO, x_do);
            chk("done", done, x_done);
            chk("rd_valid", rd_valid, x_rv);
            if (x_rv) begin
                chk("rd_data", rd_data, mem_byte(m_addr + 24'(k)));
                chk("rd_owner", rd_owner, m_owner);
            end
            if (rst) begin
                m_active = 0;
                m_last   = 1'b1;
            end else if (m_active) begin
                if (m_e >= m_end) m_active = 0;
                else m_e++;
            end else if (x_ready != 2'b00) begin
                m_owner  = x_ready[1];
                m_last   = x_ready[1];
                m_addr   = x_ready[1] ? req_addr[47:24] : req_addr[23:0];
                m_len    = x_ready[1] ? int'(req_len[31:16]) : int'(req_len[15:0]);
                m_total  = BYTE_CYC * (HDR + m_len);
                m_end    = (m_len == 0) ? 1 : m_total + CS_HIGH_MIN;
                m_e      = 1;
                m_active = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] v, input logic [23:0] a0, input logic [15:0] l0,
                         input logic [23:0] a1, input logic [15:0] l1);
        logic [1:0] got;
        req_addr  = {a1, a0};
        req_len   = {l1, l0};
        req_valid = v;
        for (int i = 0; i < 2000 && req_valid != 2'b00; i++) begin
            @(negedge clk);
            got = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~got;
        end
        chk("accept_all", req_valid, 2'b00);
        req_valid = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("wait_idle", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin : main
        int acc;
        rst = 1'b1; req_valid = 2'b11; req_addr = '0; req_len = '0; M25_DI = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ncs", M25_NCS, 1'b1);
        chk("rst_sck", M25_CLK, 1'b0);
        chk("rst_do", M25_DO, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_owner", rd_owner, 1'b0);
        chk("rst_done", done, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 2'b00);
        rst = 1'b0; req_valid = 2'b00; chk_en = 1;

        // 1: single read of two bytes
        clear_logs();
        issue(2'b01, 24'h000100, 16'd2, 24'h0, 16'd0);
        wait_idle();
        chk("t1_do_bytes", do_log.size() >= 4, 1'b1);
        chk("t1_op", do_log[0], OPC);
        chk("t1_a2", do_log[1], 8'h00);
        chk("t1_a1", do_log[2], 8'h01);
        chk("t1_a0", do_log[3], 8'h00);
        chk("t1_nbytes", rv_log.size(), 2);
        chk("t1_byte0", rv_log[0], 9'h0A5);
        chk("t1_byte1", rv_log[1], 9'h05A);
        chk("t1_ndone", done_log.size(), 1);
        chk("t1_done", done_log[0], 2'b01);
        chk("t1_ncs_n", ncs_lens.size(), 1);
`ifdef SPI_FLASH_ARB_FAST_READ_EN
        chk("t1_ncs_low", ncs_lens[0], 224);
`else
        chk("t1_ncs_low", ncs_lens[0], 192);
`endif

        // 2: simultaneous requests after reset, then again
        pulse_rst();
        clear_logs();
        issue(2'b11, 24'h000200, 16'd1, 24'h000300, 16'd1);
        wait_idle();
        chk("t2_n", acc_log.size(), 2);
        chk("t2_first", acc_log[0], 0);
        chk("t2_second", acc_log[1], 1);
        chk("t2_gap", (gap_lens.size() > 0) && (gap_lens[$] >= CS_HIGH_MIN), 1'b1);
        clear_logs();
        issue(2'b11, 24'h000210, 16'd1, 24'h000310, 16'd1);
        wait_idle();
        chk("t2b_first", acc_log[0], 0);
        chk("t2b_second", acc_log[1], 1);

        // 3: null request from requester 1
        clear_logs();
        issue(2'b10, 24'h0, 16'd0, 24'h000777, 16'd0);
        wait_idle();
        chk("t3_ndone", done_log.size(), 1);
        chk("t3_done", done_log[0], 2'b10);
        chk("t3_sck", sck_rises, 0);
        chk("t3_ncs", ncs_lens.size() + lo_cnt, 0);

        // 4: reset during the second data byte
        clear_logs();
        issue(2'b01, 24'h000400, 16'd3, 24'h0, 16'd0);
        for (int i = 0; i < 2000 && rv_log.size() < 1; i++) @(negedge clk);
        chk("t4_first_byte", rv_log.size(), 1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_ncs", M25_NCS, 1'b1);
        chk("t4_sck", M25_CLK, 1'b0);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("t4_no_more_rv", rv_log.size(), 1);
        chk("t4_no_done", done_log.size(), 0);
        issue(2'b01, 24'h000101, 16'd1, 24'h0, 16'd0);
        wait_idle();
        chk("t4_new_rv", rv_log[$], 9'h05A);

`ifdef SPI_FLASH_ARB_FAST_READ_EN
        // 5: fast read with dummy byte
        clear_logs();
        issue(2'b01, 24'h123456, 16'd1, 24'h0, 16'd0);
        wait_idle();
        chk("t5_op", do_log[0], 8'h0B);
        chk("t5_a2", do_log[1], 8'h12);
        chk("t5_a1", do_log[2], 8'h34);
        chk("t5_a0", do_log[3], 8'h56);
        chk("t5_rv", rv_log[0], 9'h08E);
        chk("t5_ncs_low", ncs_lens[0], 2*CLK_DIV*8*6);
        chk("t5_sck", sck_rises, 48);
`endif

        // 6: back-to-back single-byte reads with req_valid held
        clear_logs();
        req_addr = {24'h0, 24'h000500}; req_len = {16'd0, 16'd1}; req_valid = 2'b01;
        acc = 0;
        for (int i = 0; i < 2000 && acc < 2; i++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            @(posedge clk); #1;
            if (acc == 2) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        chk("t6_accepts", acc, 2);
        wait_idle();
        chk("t6_ntx", ncs_lens.size(), 2);
        chk("t6_gap", (gap_lens.size() > 0) && (gap_lens[$] >= CS_HIGH_MIN), 1'b1);
        chk("t6_nrv", rv_log.size(), 2);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
